// File: rtl/fir_coef_pkg.sv
// Shared types and defaults for the FIR coefficient loader.
package fir_coef_pkg;

    localparam int unsigned BYTES_PER_COEF = 3;
    localparam int unsigned NTAPS_DEF      = 64;
    localparam int unsigned CW_DEF         = 17;
    localparam int unsigned STROBE_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

    // Address width for a table of n entries (at least one bit).
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_coef_loader_if.sv
// Byte-stream source and FIR coefficient port, bundled for the loader.
interface fir_coef_loader_if #(
    parameter int unsigned CW = 17,
    parameter int unsigned AW = 6
);
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [CW-1:0] cin;
    logic [AW-1:0] caddr;
    logic          cload;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, cin, caddr, cload
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, cin, caddr, cload
    );
endinterface

// File: rtl/fir_coef_packer.sv
// Assembles LSB-first bytes into one coefficient word and flags a bad top byte.
module fir_coef_packer
    import fir_coef_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [7:0]    i_byte_in,
    output logic [CW-1:0] o_word,
    output logic          o_last_c,
    output logic          o_fmt_err_c
);
    localparam int unsigned IW = 2;

    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_word;

    assign o_last_c    = (r_idx == IW'(BYTES_PER_COEF - 1));
    assign o_fmt_err_c = i_en && o_last_c && (|i_byte_in[7:1]);
    assign o_word      = r_word;

    // Only bit 0 of the top byte is meaningful; upper bits are reported, not stored.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            case (r_idx)
                IW'(0):  r_word[7:0]  <= i_byte_in;
                IW'(1):  r_word[15:8] <= i_byte_in;
                default: r_word[CW-1] <= i_byte_in[0];
            endcase
            r_idx <= o_last_c ? '0 : r_idx + IW'(1);
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Streams NTAPS coefficients into the FIR coefficient port with a timed cload strobe.
module fir_coef_loader
    import fir_coef_pkg::*;
#(
    parameter int unsigned NTAPS      = NTAPS_DEF,
    parameter int unsigned CW         = CW_DEF,
    parameter int unsigned STROBE_CYC = STROBE_CYC_DEF
) (
    input  logic              clk_fast,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    fir_coef_loader_if.master bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int unsigned AW  = addr_w(NTAPS);
    localparam int unsigned SCW = $clog2(STROBE_CYC + 1);

    state_e         r_state;
    state_e         w_next;
    logic [AW-1:0]  r_caddr;
    logic [SCW-1:0] r_scnt;
    logic           r_byte_ready;
    logic           r_cload;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [CW-1:0]  w_word;
    logic           w_last_c;
    logic           w_fmt_err_c;
    logic           w_xfer;
    logic           w_start_ok;

    assign w_xfer     = r_byte_ready && bus.byte_valid;
    assign w_start_ok = (r_state == ST_IDLE) && i_start && !i_abort;

    fir_coef_packer #(.CW(CW)) u_packer (
        .clk_fast    (clk_fast),
        .rst_n       (rst_n),
        .i_clr       (w_start_ok),
        .i_en        (w_xfer),
        .i_byte_in   (bus.byte_in),
        .o_word      (w_word),
        .o_last_c    (w_last_c),
        .o_fmt_err_c (w_fmt_err_c)
    );

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state; abort overrides everything, including a start in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_next = ST_COLLECT;
            ST_COLLECT: if (w_xfer && w_last_c) w_next = ST_SETUP;
            ST_SETUP:   w_next = ST_STROBE;
            ST_STROBE:  if (r_scnt == SCW'(STROBE_CYC - 1)) w_next = ST_HOLD;
            ST_HOLD:    w_next = (r_caddr == AW'(NTAPS - 1)) ? ST_DONE : ST_COLLECT;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (i_abort) w_next = ST_IDLE;
    end

    // Outputs are registered from the next state so they track the FSM with no extra lag.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_ready <= 1'b0;
            r_cload      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_scnt       <= '0;
            r_caddr      <= '0;
        end else begin
            r_byte_ready <= (w_next == ST_COLLECT);
            r_cload      <= (w_next == ST_STROBE);
            r_busy       <= (w_next != ST_IDLE);
            r_done       <= (w_next == ST_DONE);
            r_scnt       <= ((r_state == ST_STROBE) && (w_next == ST_STROBE))
                            ? r_scnt + SCW'(1) : '0;
            if ((w_next == ST_IDLE) || (w_next == ST_DONE) || (r_state == ST_IDLE))
                r_caddr <= '0;
            else if (r_state == ST_HOLD)
                r_caddr <= r_caddr + AW'(1);
            if (w_start_ok)
                r_err <= 1'b0;
            else if (w_fmt_err_c)
                r_err <= 1'b1;
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.cin        = w_word;
    assign bus.caddr      = r_caddr;
    assign bus.cload      = r_cload;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: table of full-load scenarios plus abort/idle sequences.
module tb_fir_coef_loader;

    localparam int NTAPS = 64;

    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;
    logic i_start  = 1'b0;
    logic i_abort  = 1'b0;
    logic busy, done, err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fir_coef_loader_if #(.CW(17), .AW(6)) bus ();

    fir_coef_loader dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .bus      (bus),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err)
    );

    initial forever #5 clk_fast = ~clk_fast;
    initial forever begin @(posedge clk_fast); cyc++; end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    typedef struct {
        int         max_gap;
        int         bad_addr;
        logic [7:0] bad_b2;
        logic [7:0] b1_key;
        logic       extra_starts;
        logic       exp_err;
        logic       chk_done_cyc;
    } scen_t;

    logic [16:0] exp_cin [NTAPS];
    logic        mon_en = 1'b0;
    int          n_writes, n_done, done_cyc, exp_addr, width;
    logic        err_at_done;
    logic        p_cload;
    logic [16:0] p_cin, s_cin;
    logic [5:0]  p_caddr, s_caddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Write monitor: address/value per pulse, pulse width, stability from SETUP through HOLD.
    initial begin
        p_cload = 1'b0; p_cin = '0; p_caddr = '0;
        forever begin
            @(negedge clk_fast);
            if (done) begin
                n_done++;
                done_cyc    = cyc;
                err_at_done = err;
            end
            if (mon_en) begin
                if (bus.cload && !p_cload) begin
                    chk($sformatf("caddr_write%0d", exp_addr), 32'(bus.caddr), 32'(exp_addr));
                    chk($sformatf("cin_write%0d", exp_addr), 32'(bus.cin),
                        32'(exp_cin[exp_addr % NTAPS]));
                    chk("setup_stable", 32'({p_caddr, p_cin}), 32'({bus.caddr, bus.cin}));
                    s_cin = bus.cin; s_caddr = bus.caddr; width = 1;
                end else if (bus.cload) begin
                    width++;
                end else if (p_cload) begin
                    chk("strobe_width", 32'(width), 32'd2);
                    chk("hold_stable", 32'({bus.caddr, bus.cin}), 32'({s_caddr, s_cin}));
                    n_writes++;
                    exp_addr++;
                end
            end
            p_cload = bus.cload; p_cin = bus.cin; p_caddr = bus.caddr;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk_fast); #1; end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk_fast);
            if (bus.byte_ready) got = 1'b1;
        end
        if (!got) chk("byte_accept", 32'(bus.byte_ready), 32'd1);
        else begin @(posedge clk_fast); #1; end
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start(output int s0);
        i_start = 1'b1;
        s0      = cyc;
        @(posedge clk_fast); #1;
        i_start = 1'b0;
    endtask

    task automatic stray_starts();
        repeat (30) @(posedge clk_fast);
        #1 i_start = 1'b1;
        @(posedge clk_fast); #1 i_start = 1'b0;
        repeat (200) @(posedge clk_fast);
        #1 i_start = 1'b1;
        @(posedge clk_fast); #1 i_start = 1'b0;
    endtask

    function automatic logic [7:0] top_byte(input scen_t s, input int k);
        return (k == s.bad_addr) ? s.bad_b2 : 8'h01;
    endfunction

    task automatic run_load(input scen_t s, input string tag);
        int s0;
        for (int k = 0; k < NTAPS; k++) begin
            logic [7:0] b2 = top_byte(s, k);
            exp_cin[k] = {b2[0], 8'(k) ^ s.b1_key, 8'(k)};
        end
        n_writes = 0; n_done = 0; exp_addr = 0; done_cyc = -1;
        err_at_done = ~s.exp_err;
        mon_en = 1'b1;
        pulse_start(s0);
        chk({tag, "_err_cleared"}, 32'(err), 32'd0);
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < NTAPS; k++) begin
            send_byte(8'(k), (s.max_gap > 0) ? int'($urandom_range(s.max_gap, 0)) : 0);
            send_byte(8'(k) ^ s.b1_key, (s.max_gap > 0) ? int'($urandom_range(s.max_gap, 0)) : 0);
            send_byte(top_byte(s, k), (s.max_gap > 0) ? int'($urandom_range(s.max_gap, 0)) : 0);
        end
        for (int n = 0; n < 100 && n_done == 0; n++) @(negedge clk_fast);
        @(posedge clk_fast); #1;
        chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        chk({tag, "_caddr_after_done"}, 32'(bus.caddr), 32'd0);
        chk({tag, "_writes"}, 32'(n_writes), 32'(NTAPS));
        chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
        chk({tag, "_err_at_done"}, 32'(err_at_done), 32'(s.exp_err));
        if (s.chk_done_cyc) chk({tag, "_done_cycle"}, 32'(done_cyc - s0), 32'd449);
        mon_en = 1'b0;
    endtask

    scen_t tbl [5];
    int    s0;

    initial begin
        tbl[0] = '{max_gap: 0, bad_addr: -1, bad_b2: 8'h00, b1_key: 8'h00, extra_starts: 1'b0, exp_err: 1'b0, chk_done_cyc: 1'b1};
        tbl[1] = '{max_gap: 5, bad_addr: -1, bad_b2: 8'h00, b1_key: 8'h5A, extra_starts: 1'b0, exp_err: 1'b0, chk_done_cyc: 1'b0};
        tbl[2] = '{max_gap: 0, bad_addr:  5, bad_b2: 8'h03, b1_key: 8'h00, extra_starts: 1'b0, exp_err: 1'b1, chk_done_cyc: 1'b1};
        tbl[3] = '{max_gap: 2, bad_addr: 20, bad_b2: 8'hFE, b1_key: 8'hFF, extra_starts: 1'b0, exp_err: 1'b1, chk_done_cyc: 1'b0};
        tbl[4] = '{max_gap: 0, bad_addr: 63, bad_b2: 8'h00, b1_key: 8'h3C, extra_starts: 1'b1, exp_err: 1'b0, chk_done_cyc: 1'b1};

        bus.byte_in = 8'h00; bus.byte_valid = 1'b0;

        // Reset and idle with a valid byte presented but no start.
        repeat (3) @(posedge clk_fast);
        #1 chk("reset_outputs", 32'({busy, done, err, bus.byte_ready, bus.cload, bus.caddr, bus.cin}), 32'd0);
        rst_n = 1'b1;
        bus.byte_in = 8'h77; bus.byte_valid = 1'b1;
        repeat (20) begin
            @(negedge clk_fast);
            chk("idle_byte_ready", 32'(bus.byte_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        chk("idle_outputs", 32'({busy, done, err, bus.cload, bus.caddr, bus.cin}), 32'd0);
        bus.byte_valid = 1'b0;
        @(posedge clk_fast); #1;

        // Abort together with start in IDLE: no sequence begins.
        i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk_fast); #1;
        i_start = 1'b0; i_abort = 1'b0;
        chk("abort_wins_busy", 32'(busy), 32'd0);
        chk("abort_wins_ready", 32'(bus.byte_ready), 32'd0);
        @(posedge clk_fast); #1;
        chk("abort_wins_busy2", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].extra_starts)
                fork
                    run_load(tbl[i], $sformatf("scen%0d", i));
                    stray_starts();
                join
            else
                run_load(tbl[i], $sformatf("scen%0d", i));
        end

        // Abort during the strobe of address 10, with a format error at address 5.
        for (int k = 0; k < NTAPS; k++) exp_cin[k] = {(k == 5) ? 1'b1 : 1'b1, 8'h00, 8'(k)};
        n_writes = 0; n_done = 0; exp_addr = 0;
        mon_en = 1'b1;
        pulse_start(s0);
        for (int k = 0; k <= 10; k++) begin
            send_byte(8'(k), 0);
            send_byte(8'h00, 0);
            send_byte((k == 5) ? 8'h03 : 8'h01, 0);
        end
        @(posedge clk_fast); #1;
        mon_en = 1'b0;
        chk("abort_pre_cload", 32'(bus.cload), 32'd1);
        chk("abort_pre_caddr", 32'(bus.caddr), 32'd10);
        chk("abort_pre_writes", 32'(n_writes), 32'd10);
        i_abort = 1'b1;
        @(posedge clk_fast); #1;
        i_abort = 1'b0;
        chk("abort_cload", 32'(bus.cload), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_caddr", 32'(bus.caddr), 32'd0);
        chk("abort_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("abort_err_kept", 32'(err), 32'd1);
        repeat (10) @(negedge clk_fast);
        chk("abort_no_done", 32'(n_done), 32'd0);
        @(posedge clk_fast); #1;

        run_load(tbl[0], "reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
